// File: rtl/apb_bridge.sv
// Single-outstanding bridge from the core's valid/ready load/store port to APB.
// One request at a time: address decode, SETUP/ACCESS with wait-state timeout, held response.
module apb_bridge #(
  parameter logic [31:0] BASE    = 32'h2000_0000,
  parameter logic [31:0] SIZE    = 32'h0000_1000,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        Pclk,
  input  logic        Prst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] Paddr,
  output logic        Pwrite,
  output logic        Psel,
  output logic        Penable,
  output logic [31:0] Pwdata,
  input  logic [31:0] Prdata,
  input  logic        Pready,
  input  logic        Pslverr
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;

  logic             w_accept;
  logic             w_addr_ok;
  logic [CNT_W-1:0] w_wait_next;
  logic             w_timeout;

  assign req_ready = (r_state == S_IDLE) && !Prst;
  assign w_accept  = req_valid && req_ready;

  // Offset compare covers both ends of the window, including addresses below BASE.
  assign w_addr_ok   = (req_addr[1:0] == 2'b00) && ((req_addr - BASE) < SIZE);
  assign w_wait_next = r_wait_cnt + CNT_W'(1);
  assign w_timeout   = (TIMEOUT != 0) && (w_wait_next == CNT_W'(TIMEOUT));

  always_ff @(posedge Pclk) begin
    if (Prst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      Psel       <= 1'b0;
      Penable    <= 1'b0;
      Paddr      <= '0;
      Pwrite     <= 1'b0;
      Pwdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_addr_ok) begin
              Paddr      <= req_addr;
              Pwrite     <= req_write;
              Pwdata     <= req_wdata;
              Psel       <= 1'b1;
              Penable    <= 1'b0;
              r_wait_cnt <= '0;
              r_state    <= S_SETUP;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              r_state   <= S_RESP;
            end
          end
        end
        S_SETUP: begin
          Penable <= 1'b1;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (Pready) begin
            Psel      <= 1'b0;
            Penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= Pslverr;
            rsp_rdata <= (!Pwrite && !Pslverr) ? Prdata : '0;
            r_state   <= S_RESP;
          end else if (w_timeout) begin
            Psel      <= 1'b0;
            Penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            r_state   <= S_RESP;
          end else begin
            r_wait_cnt <= w_wait_next;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bridge.sv
// Self-checking bench for apb_bridge: expected responses are queued at request time
// and compared by a monitor at each response handshake; tasks check APB timing inline.
module tb_apb_bridge;

  logic        Pclk = 1'b0;
  logic        Prst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] Paddr;
  logic        Pwrite;
  logic        Psel;
  logic        Penable;
  logic [31:0] Pwdata;
  logic [31:0] Prdata = '0;
  logic        Pready = 1'b1;
  logic        Pslverr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int accept_cyc = 0;

  logic [32:0] exp_q [$];

  apb_bridge #(
    .BASE   (32'h2000_0000),
    .SIZE   (32'h0000_1000),
    .TIMEOUT(16)
  ) dut (
    .Pclk     (Pclk),
    .Prst     (Prst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_write(req_write),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .Paddr    (Paddr),
    .Pwrite   (Pwrite),
    .Psel     (Psel),
    .Penable  (Penable),
    .Pwdata   (Pwdata),
    .Prdata   (Prdata),
    .Pready   (Pready),
    .Pslverr  (Pslverr)
  );

  always #5 Pclk = ~Pclk;

  always @(posedge Pclk) cyc <= cyc + 1;

  // Scoreboard: a response handshake happens at the next posedge.
  always @(negedge Pclk) begin
    if (!Prst && rsp_valid && rsp_ready) begin
      logic [32:0] e;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b, required no response", rsp_rdata, rsp_err);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_err, rsp_rdata} !== e) begin
          n_fail++;
          $display("FAIL rsp_payload: got err=%b rdata=%h, required err=%b rdata=%h",
                   rsp_err, rsp_rdata, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Pclk);
    #1;
  endtask

  // Present a request and return one step after the accepting edge.
  task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d);
    req_addr  = a;
    req_write = w;
    req_wdata = d;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !req_ready; i++) tick();
    n_tests++;
    if (!req_ready) begin
      n_fail++;
      $display("FAIL send_ready: got req_ready=0, required 1 within 50 cycles");
    end
    tick();
    accept_cyc = cyc;
    req_valid  = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && !req_ready; i++) tick();
    n_tests++;
    if (!req_ready) begin
      n_fail++;
      $display("FAIL wait_idle: got req_ready=0, required 1 within 60 cycles");
    end
  endtask

  task automatic test_reset();
    Prst = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({rsp_valid, rsp_err, Psel, Penable, Pwrite, req_ready} !== 6'b0 ||
        rsp_rdata !== 32'h0 || Paddr !== 32'h0 || Pwdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values: got valid=%b err=%b sel=%b en=%b wr=%b rdy=%b rdata=%h addr=%h wdata=%h, required all 0",
               rsp_valid, rsp_err, Psel, Penable, Pwrite, req_ready, rsp_rdata, Paddr, Pwdata);
    end
    Prst = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b, required 1", req_ready);
    end
  endtask

  task automatic test_write();
    Pready = 1'b1;
    exp_q.push_back({1'b0, 32'h0});
    send(32'h2000_0000, 1'b1, 32'h1234_5678);
    n_tests++;
    if (Psel !== 1'b1 || Penable !== 1'b0 || Pwrite !== 1'b1 ||
        Pwdata !== 32'h1234_5678 || Paddr !== 32'h2000_0000) begin
      n_fail++;
      $display("FAIL write_setup: got sel=%b en=%b wr=%b wdata=%h addr=%h, required 1 0 1 12345678 20000000",
               Psel, Penable, Pwrite, Pwdata, Paddr);
    end
    tick();
    n_tests++;
    if (Psel !== 1'b1 || Penable !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL write_access: got sel=%b en=%b valid=%b, required 1 1 0", Psel, Penable, rsp_valid);
    end
    tick();
    n_tests++;
    if (rsp_valid !== 1'b1 || Psel !== 1'b0 || Penable !== 1'b0) begin
      n_fail++;
      $display("FAIL write_resp: got valid=%b sel=%b en=%b, required 1 0 0", rsp_valid, Psel, Penable);
    end
    wait_idle();
  endtask

  task automatic test_read_wait();
    int en_cnt = 0;
    Pready = 1'b0;
    Prdata = 32'hA5A5_0001;
    exp_q.push_back({1'b0, 32'hA5A5_0001});
    send(32'h2000_0004, 1'b0, 32'h0);
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      tick();
      if (Penable) en_cnt++;
      if (en_cnt == 4) Pready = 1'b1;
      if (Psel && (Paddr !== 32'h2000_0004 || Pwrite !== 1'b0)) begin
        n_fail++;
        $display("FAIL read_addr_stable: got addr=%h wr=%b, required 20000004 0", Paddr, Pwrite);
      end
    end
    n_tests++;
    if (en_cnt != 4) begin
      n_fail++;
      $display("FAIL read_wait_penable_cycles: got %0d, required 4", en_cnt);
    end
    Pready = 1'b1;
    wait_idle();
  endtask

  task automatic test_slverr();
    Pready  = 1'b1;
    Pslverr = 1'b1;
    Prdata  = 32'hDEAD_BEEF;
    exp_q.push_back({1'b1, 32'h0});
    send(32'h2000_0008, 1'b0, 32'h0);
    wait_idle();
    Pslverr = 1'b0;
  endtask

  task automatic test_decode_err();
    logic [31:0] addrs [2];
    addrs[0] = 32'h2000_0002;
    addrs[1] = 32'h3000_0000;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({1'b1, 32'h0});
      send(addrs[k], 1'b0, 32'h0);
      n_tests++;
      if (rsp_valid !== 1'b1 || Psel !== 1'b0) begin
        n_fail++;
        $display("FAIL decode_err_%0d: got valid=%b sel=%b, required 1 0", k, rsp_valid, Psel);
      end
      tick();
      n_tests++;
      if (Psel !== 1'b0) begin
        n_fail++;
        $display("FAIL decode_err_psel_%0d: got %b, required 0", k, Psel);
      end
      wait_idle();
    end
  endtask

  task automatic test_timeout();
    int en_cnt = 0;
    Pready = 1'b0;
    exp_q.push_back({1'b1, 32'h0});
    send(32'h2000_000C, 1'b0, 32'h0);
    for (int i = 0; i < 100 && !rsp_valid; i++) begin
      tick();
      if (Penable) en_cnt++;
    end
    n_tests++;
    if (en_cnt != 16) begin
      n_fail++;
      $display("FAIL timeout_access_cycles: got %0d, required 16", en_cnt);
    end
    wait_idle();
    Pready = 1'b1;
    Prdata = 32'h0000_0011;
    exp_q.push_back({1'b0, 32'h0000_0011});
    send(32'h2000_0000, 1'b0, 32'h0);
    wait_idle();
  endtask

  task automatic test_backpressure();
    Pready    = 1'b1;
    rsp_ready = 1'b0;
    Prdata    = 32'hCAFE_0003;
    exp_q.push_back({1'b0, 32'hCAFE_0003});
    send(32'h2000_000C, 1'b0, 32'h0);
    tick();
    tick();
    Prdata = 32'h5555_AAAA;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_0003 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold_%0d: got valid=%b rdata=%h err=%b rdy=%b, required 1 cafe0003 0 0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_mid_reset();
    Pready = 1'b0;
    send(32'h2000_0004, 1'b1, 32'hFFFF_0000);
    tick();
    n_tests++;
    if (Penable !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_in_access: got en=%b, required 1", Penable);
    end
    Prst = 1'b1;
    tick();
    n_tests++;
    if (Psel !== 1'b0 || Penable !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_clear: got sel=%b en=%b valid=%b rdy=%b, required 0 0 0 0",
               Psel, Penable, rsp_valid, req_ready);
    end
    Prst   = 1'b0;
    Pready = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_ready: got %b, required 1", req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_no_rsp: got valid=%b, required 0", rsp_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int prev;
    Pready    = 1'b1;
    rsp_ready = 1'b1;
    Prdata    = 32'h0BAD_F00D;
    exp_q.push_back({1'b0, 32'h0});
    send(32'h2000_0000, 1'b1, 32'h0000_0001);
    prev = accept_cyc;
    wait_idle();
    exp_q.push_back({1'b0, 32'h0BAD_F00D});
    send(32'h2000_0008, 1'b0, 32'h0);
    n_tests++;
    if (accept_cyc - prev != 4) begin
      n_fail++;
      $display("FAIL b2b_interval_1: got %0d, required 4", accept_cyc - prev);
    end
    prev = accept_cyc;
    wait_idle();
    exp_q.push_back({1'b0, 32'h0});
    send(32'h2000_0FFC, 1'b1, 32'h0000_0002);
    n_tests++;
    if (accept_cyc - prev != 4) begin
      n_fail++;
      $display("FAIL b2b_interval_2: got %0d, required 4", accept_cyc - prev);
    end
    n_tests++;
    if (Psel !== 1'b1 || Paddr !== 32'h2000_0FFC || Pwdata !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL b2b_last_word: got sel=%b addr=%h wdata=%h, required 1 20000ffc 00000002", Psel, Paddr, Pwdata);
    end
    wait_idle();
  endtask

  initial begin
    #1;
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_decode_err();
    test_timeout();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    tick();
    tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending responses, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
